// File: rtl/floor_req_conditioner.sv
// Debounces N_BTN bouncing floor buttons into one-cycle press pulses and a clean level.
// Press pulse appears DEBOUNCE_CYCLES+2 edges after the first high sample; no backpressure, outputs are free-running.
module floor_req_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] floor_req,
    output logic [N_BTN-1:0] btn_level
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t      state_q;
        state_t      state_d;
        logic [15:0] cnt_q;
        logic [15:0] cnt_d;
        logic        req_d;
        logic        req_q;
        logic        lvl_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            req_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2[i]) begin
                        state_d = ARMING;
                        cnt_d   = '0;
                    end
                end
                ARMING: begin
                    if (!s2[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = HELD;
                        req_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                HELD: begin
                    if (!s2[i]) begin
                        state_d = RELEASING;
                        cnt_d   = '0;
                    end
                end
                RELEASING: begin
                    // A high sample mid-release is bounce: the press is still in effect.
                    if (s2[i]) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
                lvl_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= req_d;
                lvl_q   <= (state_d == HELD) || (state_d == RELEASING);
            end
        end

        assign floor_req[i] = req_q;
        assign btn_level[i] = lvl_q;
    end

endmodule

// File: tb/tb_floor_req_conditioner.sv
// Directed bench for floor_req_conditioner with DEBOUNCE_CYCLES=4; edge i is the i-th posedge after inputs change.
module tb_floor_req_conditioner;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] floor_req;
    logic [N-1:0] btn_level;

    int tests = 0;
    int fails = 0;

    floor_req_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .floor_req (floor_req),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_raw = '0;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        btn_raw = '0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (floor_req !== 4'b0000 || btn_level !== 4'b0000) begin
            $display("FAIL reset_async: floor_req=%b btn_level=%b expected 0000/0000", floor_req, btn_level);
            fails++;
        end
        repeat (2) step();
        tests++;
        if (floor_req !== 4'b0000 || btn_level !== 4'b0000) begin
            $display("FAIL reset_clocked: floor_req=%b btn_level=%b expected 0000/0000", floor_req, btn_level);
            fails++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pedge  = -1;
        int fall   = -1;
        int rel_pulses = 0;
        logic [N-1:0] req6 = '0;
        logic [N-1:0] lvl5 = '0;
        logic [N-1:0] lvl6 = '0;
        btn_raw = 4'b0100;
        for (int i = 0; i < 50; i++) begin
            step();
            if (floor_req != 0) begin
                pulses++;
                if (pedge < 0) pedge = i;
            end
            if (i == 5) lvl5 = btn_level;
            if (i == 6) begin
                lvl6 = btn_level;
                req6 = floor_req;
            end
        end
        tests++;
        if (pulses !== 1) begin
            $display("FAIL clean_pulse_count: got %0d expected 1", pulses); fails++;
        end
        tests++;
        if (pedge !== 6 || req6 !== 4'b0100) begin
            $display("FAIL clean_pulse_edge: edge %0d value %b expected edge 6 value 0100", pedge, req6); fails++;
        end
        tests++;
        if (lvl5 !== 4'b0000 || lvl6 !== 4'b0100 || btn_level !== 4'b0100) begin
            $display("FAIL clean_level: e5=%b e6=%b end=%b expected 0000/0100/0100", lvl5, lvl6, btn_level); fails++;
        end
        btn_raw = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fall < 0 && btn_level[2] == 1'b0) fall = i;
            if (floor_req != 0) rel_pulses++;
        end
        tests++;
        if (fall !== 6 || rel_pulses !== 0) begin
            $display("FAIL clean_release: fall edge %0d pulses %0d expected 6 and 0", fall, rel_pulses); fails++;
        end
    endtask

    task automatic test_press_bounce();
        int pulses = 0;
        int pedge  = -1;
        for (int i = 0; i < 40; i++) begin
            btn_raw = (i == 2) ? 4'b0000 : 4'b0010;
            step();
            if (floor_req != 0) begin
                pulses++;
                if (pedge < 0) pedge = i;
            end
        end
        tests++;
        if (pulses !== 1 || pedge !== 9) begin
            $display("FAIL press_bounce: pulses %0d at edge %0d expected 1 at edge 9", pulses, pedge); fails++;
        end
        settle();
    endtask

    task automatic test_release_bounce();
        int pulses = 0;
        int fall   = -1;
        btn_raw = 4'b0001;
        repeat (20) step();
        tests++;
        if (btn_level !== 4'b0001) begin
            $display("FAIL release_bounce_held: btn_level=%b expected 0001", btn_level); fails++;
        end
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i == 1) ? 4'b0001 : 4'b0000;
            step();
            if (fall < 0 && btn_level[0] == 1'b0) fall = i;
            if (floor_req != 0) pulses++;
        end
        tests++;
        if (fall !== 8 || pulses !== 0) begin
            $display("FAIL release_bounce: fall edge %0d pulses %0d expected 8 and 0", fall, pulses); fails++;
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int nz = 0;
        logic [N-1:0] req6 = '0;
        btn_raw = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            step();
            if (floor_req != 0) nz++;
            if (i == 6) req6 = floor_req;
        end
        tests++;
        if (req6 !== 4'b1001 || nz !== 1) begin
            $display("FAIL simultaneous: e6 value %b active cycles %0d expected 1001 and 1", req6, nz); fails++;
        end
        settle();
    endtask

    task automatic test_staggered();
        int nz = 0;
        logic [N-1:0] req6 = '0;
        logic [N-1:0] req8 = '0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i >= 2) ? 4'b0101 : 4'b0001;
            step();
            if (floor_req != 0) nz++;
            if (i == 6) req6 = floor_req;
            if (i == 8) req8 = floor_req;
        end
        tests++;
        if (req6 !== 4'b0001 || req8 !== 4'b0100 || nz !== 2) begin
            $display("FAIL staggered: e6 %b e8 %b active %0d expected 0001 0100 2", req6, req8, nz); fails++;
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int early = 0;
        int during = 0;
        int pulses = 0;
        int pedge  = -1;
        btn_raw = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step();
            if (floor_req != 0) early++;
        end
        rst_n = 1'b0;
        #1;
        if (floor_req != 0 || btn_level != 0) during++;
        repeat (2) begin
            step();
            if (floor_req != 0 || btn_level != 0) during++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (floor_req != 0) begin
                pulses++;
                if (pedge < 0) pedge = i;
            end
        end
        tests++;
        if (early !== 0 || during !== 0) begin
            $display("FAIL reset_mid_quiet: early pulses %0d nonzero-in-reset %0d expected 0 and 0", early, during); fails++;
        end
        tests++;
        if (pulses !== 1 || pedge !== 6) begin
            $display("FAIL reset_mid_pulse: pulses %0d at edge %0d expected 1 at edge 6", pulses, pedge); fails++;
        end
    endtask

    task automatic test_reset_held();
        int pulses = 0;
        int pedge  = -1;
        tests++;
        if (btn_level !== 4'b1000) begin
            $display("FAIL reset_held_pre: btn_level=%b expected 1000", btn_level); fails++;
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (btn_level !== 4'b0000) begin
            $display("FAIL reset_held_async: btn_level=%b expected 0000", btn_level); fails++;
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (floor_req != 0) begin
                pulses++;
                if (pedge < 0) pedge = i;
            end
        end
        tests++;
        if (pulses !== 1 || pedge !== 6) begin
            $display("FAIL reset_held_repress: pulses %0d at edge %0d expected 1 at edge 6", pulses, pedge); fails++;
        end
        settle();
    endtask

    task automatic test_long_hold();
        int pulses = 0;
        int low = 0;
        btn_raw = 4'b0010;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (floor_req != 0) pulses++;
            if (i >= 6 && btn_level !== 4'b0010) low++;
        end
        tests++;
        if (pulses !== 1) begin
            $display("FAIL long_hold_pulses: got %0d expected 1", pulses); fails++;
        end
        tests++;
        if (low !== 0) begin
            $display("FAIL long_hold_level: %0d cycles with btn_level != 0010, expected 0", low); fails++;
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_simultaneous();
        test_staggered();
        test_reset_mid();
        test_reset_held();
        test_long_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/floor_req_conditioner.md
FLOOR_REQ_CONDITIONER -- requirements
Module: floor_req_conditioner

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, number of floor buttons.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-input cycles required before a press or release is accepted; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port btn_raw, input, N_BTN, asynchronous, bouncing push-button pins; bit i is floor i; 1 = pressed.
REQ-006 The block SHALL have port floor_req, output, N_BTN, registered one-cycle press pulses, one per accepted press; this port drives the elevator controller's floor_req input.
REQ-007 The block SHALL have port btn_level, output, N_BTN, registered debounced button level.

Function
REQ-008 Each btn_raw bit SHALL pass through its own 2-flop synchronizer (s1, s2); only s2 feeds the logic.
REQ-009 Each bit SHALL have an independent FSM with states IDLE, ARMING, HELD and RELEASING, plus a 16-bit counter cnt.
REQ-010 IDLE: if s2=1, the FSM SHALL go to ARMING with cnt<=0; otherwise it stays in IDLE.
REQ-011 ARMING: s2=0 SHALL return the FSM to IDLE (bounce) with cnt<=0 and no pulse.
REQ-012 ARMING: s2=1 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-013 ARMING: s2=1 with cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD and set floor_req[i]<=1 for exactly one cycle.
REQ-014 HELD: s2=0 SHALL move the FSM to RELEASING with cnt<=0; s2=1 SHALL keep it in HELD with no further pulses, however long the button is held.
REQ-015 RELEASING: s2=1 SHALL return the FSM to HELD with cnt<=0 and no pulse.
REQ-016 RELEASING: s2=0 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-017 RELEASING: s2=0 with cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to IDLE.
REQ-018 btn_level[i] SHALL be 1 exactly while the FSM is in HELD or RELEASING, registered together with the state.
REQ-019 Latency: if e0 is the first clk edge sampling btn_raw[i]=1 and the pin stays high, floor_req[i] SHALL be 1 in the cycle after edge e0+DEBOUNCE_CYCLES+2 and 0 in every other cycle.
REQ-020 btn_level[i] SHALL rise on the same edge as floor_req[i]; on a clean release first sampled at edge e1, it SHALL fall on edge e1+DEBOUNCE_CYCLES+2.
REQ-021 Bits SHALL be fully independent; simultaneous presses on several bits SHALL produce pulses in the same cycle, with no arbitration and no lost press.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-023 floor_req SHALL never be 1 for two consecutive cycles on the same bit.

Reset
REQ-024 While rst_n=0, all of the following SHALL be cleared immediately, independent of clk: s1, s2, FSMs to IDLE, cnt, floor_req, btn_level.
REQ-025 Reset deassertion SHALL be synchronized to clk externally; the block SHALL need no cycles after reset before it can accept input.
REQ-026 Reset in any state, including mid-ARMING, SHALL discard partial debounce progress and emit no pulse.
REQ-027 A button held through reset release SHALL be treated as a new press and pulse after the full REQ-019 latency.

Verification (DEBOUNCE_CYCLES=4, edges numbered from first sample)
REQ-028 Clean press: btn_raw[2] 0->1 sampled at e0 and held 50 cycles -> floor_req=4'b0100 only in the cycle after e6; btn_level[2]=1 from e6 onward.
REQ-029 Press bounce: btn_raw[1] pattern 1,1,0,1,1,1,1,1... -> exactly one floor_req[1] pulse, 4+2 edges after the last 0->1 sample.
REQ-030 Release bounce: from HELD, btn_raw[0] pattern 0,1,0,0,0,0... -> no pulse; btn_level[0] falls 6 edges after the final 0 run begins.
REQ-031 Simultaneous: btn_raw 4'b1001 at e0 -> floor_req=4'b1001 in one single cycle after e6.
REQ-032 Reset mid-operation: btn_raw[3]=1, rst_n pulsed low at e3 for 2 cycles, pin still high -> no pulse before reset; one pulse 6 edges after the first post-reset sampling edge; outputs 0 during reset.
REQ-033 Long hold: btn_raw[1]=1 for 1000 cycles -> exactly one pulse; btn_level[1] held at 1 throughout.
